// File: rtl/sys_pkg.sv
// Shared types and defaults for the systolic-array job control path.
package sys_pkg;

    localparam int unsigned SYS_M     = 2;
    localparam int unsigned SYS_K     = 2;
    localparam int unsigned SYS_BW    = 2;
    localparam int unsigned OUT_BEATS = SYS_M * SYS_K / SYS_BW;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLEAR    = 3'd1,
        ST_DISPATCH = 3'd2,
        ST_COMPUTE  = 3'd3,
        ST_COLLECT  = 3'd4,
        ST_FINISH   = 3'd5,
        ST_ERROR    = 3'd6
    } seq_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ARRAY   = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_OVERRUN = 2'd3
    } err_code_t;

endpackage

// File: rtl/sys_watchdog.sv
// Clearable, stallable saturating up-counter with an expiry flag at TIMEOUT-1.
module sys_watchdog #(
    parameter int unsigned TIMEOUT = 1024,
    localparam int unsigned WD_W   = $clog2(TIMEOUT) + 1
) (
    input  logic clk,
    input  logic nrst,
    input  logic clr,
    input  logic stall,
    output logic expired_c
);

    logic [WD_W-1:0] wd_ctr;

    // Counter: cleared on request, held while stalled, saturates at all-ones.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            wd_ctr <= '0;
        end else if (clr) begin
            wd_ctr <= '0;
        end else if (!stall && (wd_ctr != '1)) begin
            wd_ctr <= wd_ctr + WD_W'(1);
        end
    end

    assign expired_c = (wd_ctr == WD_W'(TIMEOUT - 1));

endmodule

// File: rtl/sys_job_sequencer.sv
// Job-level controller: launches one operand set through dispatch, compute and
// collection, supervises it with a per-state watchdog and reports done/err.
module sys_job_sequencer
    import sys_pkg::*;
#(
    parameter int unsigned M        = SYS_M,
    parameter int unsigned K        = SYS_K,
    parameter int unsigned BW       = SYS_BW,
    parameter int unsigned IN_BEATS = 4,
    parameter int unsigned TIMEOUT  = 1024,
    localparam int unsigned LVL_W   = $clog2(IN_BEATS) + 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic [LVL_W-1:0] in_level,
    input  logic             done_dispatch,
    input  logic             sys_comp_done,
    input  logic             sys_comp_err,
    input  logic             out_push,
    input  logic             out_full,
    output logic             dispatch_en,
    output logic             array_run,
    output logic             collect_en,
    output logic             job_clear,
    output logic             busy,
    output logic             job_done,
    output logic             job_err,
    output logic [1:0]       err_code
);

    localparam int unsigned N_OUT = M * K / BW;
    localparam int unsigned PC_W  = $clog2(N_OUT) + 1;

    seq_state_t      state_q, state_d;
    err_code_t       err_q, code_d;
    logic [PC_W-1:0] push_ctr;
    logic            wd_exp_c;
    logic            wd_clr;
    logic            wd_stall;
    logic            push_ok;
    logic            push_bad;
    logic            last_push;

    // Collector is gated directly by output-FIFO backpressure.
    assign collect_en = (state_q == ST_COLLECT) && !out_full;

    assign push_ok   = out_push && collect_en;
    assign push_bad  = out_push && !collect_en;
    assign last_push = push_ok && (push_ctr == PC_W'(N_OUT - 1));
    assign wd_clr    = (state_d != state_q);
    assign wd_stall  = (state_q == ST_COLLECT) && out_full;
    assign err_code  = err_q;

    sys_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .nrst      (nrst),
        .clr       (wd_clr),
        .stall     (wd_stall),
        .expired_c (wd_exp_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and error-code selection; errors outrank success transitions.
    always_comb begin
        state_d = state_q;
        code_d  = ERR_NONE;
        case (state_q)
            ST_IDLE: begin
                if (start && (in_level >= LVL_W'(IN_BEATS))) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = ST_DISPATCH;
            end
            ST_DISPATCH, ST_COMPUTE, ST_COLLECT: begin
                if (sys_comp_err) begin
                    state_d = ST_ERROR;
                    code_d  = ERR_ARRAY;
                end else if (wd_exp_c) begin
                    state_d = ST_ERROR;
                    code_d  = ERR_TIMEOUT;
                end else if (push_bad) begin
                    state_d = ST_ERROR;
                    code_d  = ERR_OVERRUN;
                end else begin
                    case (state_q)
                        ST_DISPATCH: begin
                            if (done_dispatch) begin
                                state_d = sys_comp_done ? ST_COLLECT : ST_COMPUTE;
                            end
                        end
                        ST_COMPUTE: begin
                            if (sys_comp_done) begin
                                state_d = ST_COLLECT;
                            end
                        end
                        default: begin
                            if (last_push) begin
                                state_d = ST_FINISH;
                            end
                        end
                    endcase
                end
            end
            ST_FINISH, ST_ERROR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output-FIFO push counter, cleared at the start of every job.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            push_ctr <= '0;
        end else if (state_q == ST_CLEAR) begin
            push_ctr <= '0;
        end else if ((state_q == ST_COLLECT) && push_ok) begin
            push_ctr <= push_ctr + PC_W'(1);
        end
    end

    // Registered outputs decoded from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            dispatch_en <= 1'b0;
            array_run   <= 1'b0;
            job_clear   <= 1'b0;
            busy        <= 1'b0;
            job_done    <= 1'b0;
            job_err     <= 1'b0;
            err_q       <= ERR_NONE;
        end else begin
            dispatch_en <= (state_d == ST_DISPATCH);
            array_run   <= (state_d == ST_DISPATCH) || (state_d == ST_COMPUTE);
            job_clear   <= (state_d == ST_CLEAR);
            busy        <= (state_d != ST_IDLE);
            job_done    <= (state_d == ST_FINISH) || (state_d == ST_ERROR);
            if (state_d == ST_ERROR) begin
                job_err <= 1'b1;
                err_q   <= code_d;
            end else if ((state_q == ST_IDLE) && (state_d == ST_CLEAR)) begin
                job_err <= 1'b0;
                err_q   <= ERR_NONE;
            end
        end
    end

endmodule

// File: tb/tb_sys_job_sequencer.sv
// Directed bench for sys_job_sequencer with a completion scoreboard.
module tb_sys_job_sequencer;

    typedef struct packed {
        logic       err;
        logic [1:0] code;
    } cpl_t;

    logic       clk;
    logic       nrst;
    logic       start;
    logic [2:0] in_level;
    logic       done_dispatch;
    logic       sys_comp_done;
    logic       sys_comp_err;
    logic       out_push;
    logic       out_full;
    logic       dispatch_en;
    logic       array_run;
    logic       collect_en;
    logic       job_clear;
    logic       busy;
    logic       job_done;
    logic       job_err;
    logic [1:0] err_code;

    cpl_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    sys_job_sequencer #(
        .M        (2),
        .K        (2),
        .BW       (2),
        .IN_BEATS (4),
        .TIMEOUT  (16)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .start         (start),
        .in_level      (in_level),
        .done_dispatch (done_dispatch),
        .sys_comp_done (sys_comp_done),
        .sys_comp_err  (sys_comp_err),
        .out_push      (out_push),
        .out_full      (out_full),
        .dispatch_en   (dispatch_en),
        .array_run     (array_run),
        .collect_en    (collect_en),
        .job_clear     (job_clear),
        .busy          (busy),
        .job_done      (job_done),
        .job_err       (job_err),
        .err_code      (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_dispatch_en"}, dispatch_en, 0);
        chk({tag, "_array_run"},   array_run,   0);
        chk({tag, "_collect_en"},  collect_en,  0);
        chk({tag, "_job_clear"},   job_clear,   0);
        chk({tag, "_busy"},        busy,        0);
        chk({tag, "_job_done"},    job_done,    0);
        chk({tag, "_job_err"},     job_err,     0);
        chk({tag, "_err_code"},    err_code,    0);
    endtask

    // Accept a job: CLEAR one cycle after start, DISPATCH the cycle after.
    task automatic start_job(input string tag);
        start    = 1'b1;
        in_level = 3'd4;
        tick();
        chk({tag, "_clear_pulse"}, job_clear, 1);
        chk({tag, "_clear_busy"},  busy,      1);
        chk({tag, "_clear_nodisp"}, dispatch_en, 0);
        start = 1'b0;
        tick();
        chk({tag, "_clear_once"}, job_clear,   0);
        chk({tag, "_disp_en"},    dispatch_en, 1);
        chk({tag, "_disp_run"},   array_run,   1);
    endtask

    // Wait (bounded) for the completion pulse and score it against the queue.
    task automatic wait_done(input string tag, input int budget);
        int   n = 0;
        cpl_t e;
        while (!job_done && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_done_seen"}, job_done, 1);
        chk({tag, "_sb_nonempty"}, exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_job_err"},  job_err,  e.err);
            chk({tag, "_err_code"}, err_code, e.code);
        end
        chk({tag, "_done_enables"}, {dispatch_en, array_run, collect_en, job_clear}, 0);
        tick();
        chk({tag, "_done_pulse"}, job_done, 0);
        chk({tag, "_idle_busy"},  busy,     0);
    endtask

    initial begin
        logic flag;
        int   n;

        nrst          = 1'b0;
        start         = 1'b0;
        in_level      = 3'd0;
        done_dispatch = 1'b0;
        sys_comp_done = 1'b0;
        sys_comp_err  = 1'b0;
        out_push      = 1'b0;
        out_full      = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        nrst = 1'b1;
        tick();
        chk("post_reset_busy", busy, 0);

        // Normal job with staggered dispatch/compute completion.
        exp_q.push_back('{err: 1'b0, code: 2'd0});
        start_job("t1");
        tick();
        tick();
        done_dispatch = 1'b1;
        tick();
        done_dispatch = 1'b0;
        chk("t1_comp_run",   array_run,   1);
        chk("t1_comp_nodisp", dispatch_en, 0);
        chk("t1_comp_busy",  busy,        1);
        tick();
        tick();
        tick();
        sys_comp_done = 1'b1;
        tick();
        sys_comp_done = 1'b0;
        chk("t1_coll_en",  collect_en, 1);
        chk("t1_coll_run", array_run,  0);
        out_push = 1'b1;
        tick();
        chk("t1_mid_push_done", job_done, 0);
        tick();
        out_push = 1'b0;
        chk("t1_finish_busy", busy, 1);
        wait_done("t1", 4);

        // Level too low: stay idle, then launch once it reaches IN_BEATS.
        exp_q.push_back('{err: 1'b0, code: 2'd0});
        start    = 1'b1;
        in_level = 3'd3;
        flag     = 1'b0;
        repeat (10) begin
            tick();
            if (busy || job_clear || dispatch_en) flag = 1'b1;
        end
        chk("t2_held_idle", flag, 0);
        in_level = 3'd4;
        tick();
        chk("t2_clear", job_clear, 1);
        start = 1'b0;
        tick();
        chk("t2_disp_latency", dispatch_en, 1);
        done_dispatch = 1'b1;
        sys_comp_done = 1'b1;
        tick();
        done_dispatch = 1'b0;
        sys_comp_done = 1'b0;
        chk("t2_skip_compute", collect_en, 1);
        chk("t2_skip_run",     array_run,  0);
        out_push = 1'b1;
        tick();
        tick();
        out_push = 1'b0;
        wait_done("t2", 4);

        // Long backpressure in COLLECT must not trip the watchdog.
        exp_q.push_back('{err: 1'b0, code: 2'd0});
        start_job("t3");
        done_dispatch = 1'b1;
        tick();
        done_dispatch = 1'b0;
        sys_comp_done = 1'b1;
        tick();
        sys_comp_done = 1'b0;
        out_push = 1'b1;
        tick();
        out_push = 1'b0;
        out_full = 1'b1;
        flag     = 1'b0;
        repeat (50) begin
            tick();
            if (collect_en || job_done || job_err) flag = 1'b1;
        end
        chk("t3_stalled", flag, 0);
        chk("t3_still_busy", busy, 1);
        out_full = 1'b0;
        tick();
        chk("t3_resume", collect_en, 1);
        out_push = 1'b1;
        tick();
        out_push = 1'b0;
        wait_done("t3", 4);

        // Compute never finishes: timeout 16 cycles into COMPUTE.
        exp_q.push_back('{err: 1'b1, code: 2'd2});
        start_job("t4");
        done_dispatch = 1'b1;
        tick();
        done_dispatch = 1'b0;
        n = 0;
        while (array_run && n < 100) begin
            n++;
            tick();
        end
        chk("t4_compute_cycles", n, 16);
        wait_done("t4", 2);
        chk("t4_err_sticky",  job_err,  1);
        chk("t4_code_sticky", err_code, 2);

        // Array error together with done_dispatch: error wins, no COLLECT.
        exp_q.push_back('{err: 1'b1, code: 2'd1});
        start_job("t5");
        chk("t5_err_cleared",  job_err,  0);
        chk("t5_code_cleared", err_code, 0);
        done_dispatch = 1'b1;
        sys_comp_err  = 1'b1;
        tick();
        done_dispatch = 1'b0;
        sys_comp_err  = 1'b0;
        chk("t5_no_collect", collect_en, 0);
        wait_done("t5", 2);

        // Push while not collecting is an overrun.
        exp_q.push_back('{err: 1'b1, code: 2'd3});
        start_job("t7");
        done_dispatch = 1'b1;
        tick();
        done_dispatch = 1'b0;
        out_push = 1'b1;
        tick();
        out_push = 1'b0;
        wait_done("t7", 2);

        // Reset in the middle of COLLECT aborts with no completion pulse.
        start_job("t6");
        chk("t6_err_cleared", job_err, 0);
        done_dispatch = 1'b1;
        sys_comp_done = 1'b1;
        tick();
        done_dispatch = 1'b0;
        sys_comp_done = 1'b0;
        out_push = 1'b1;
        tick();
        out_push = 1'b0;
        nrst     = 1'b0;
        tick();
        nrst = 1'b1;
        check_all_zero("t6_rst");
        flag = 1'b0;
        repeat (5) begin
            tick();
            if (job_done || busy) flag = 1'b1;
        end
        chk("t6_no_done", flag, 0);
        exp_q.push_back('{err: 1'b0, code: 2'd0});
        start_job("t6b");
        done_dispatch = 1'b1;
        tick();
        done_dispatch = 1'b0;
        sys_comp_done = 1'b1;
        tick();
        sys_comp_done = 1'b0;
        out_push = 1'b1;
        tick();
        tick();
        out_push = 1'b0;
        wait_done("t6b", 4);

        chk("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
